// File: rtl/cpu_regs_pkg.sv
// cpu_regs_pkg: opcodes, FSM states and flag bit positions shared by the CPU tile
package cpu_regs_pkg;
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_NOT   = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_LDI   = 4'h7;
    localparam logic [3:0] OP_ADDI  = 4'h8;
    localparam logic [3:0] OP_SHL   = 4'h9;
    localparam logic [3:0] OP_SHR   = 4'hA;
    localparam logic [3:0] OP_MOV   = 4'hB;
    localparam logic [3:0] OP_MUL   = 4'hC;
    localparam logic [3:0] OP_SHOW  = 4'hD;
    localparam logic [3:0] OP_FLAGS = 4'hE;
    localparam logic [3:0] OP_CLR   = 4'hF;
    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
    localparam int F_Z = 0;
    localparam int F_C = 1;
    localparam int F_N = 2;
endpackage

// File: rtl/tt_um_sunaofurukawa_cpu_regs_if.sv
// tt_um_sunaofurukawa_cpu_regs_if: TinyTapeout pin bundle of the CPU tile
interface tt_um_sunaofurukawa_cpu_regs_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/cpu_mul_seq.sv
// cpu_mul_seq: shift-add multiplier; lo/hi present the product after the step being taken this cycle
module cpu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    logic [WIDTH-1:0] mc, acc_hi, acc_lo;
    logic [WIDTH:0]   sum;
    assign sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mc} : '0);
    assign {hi, lo} = {sum, acc_lo[WIDTH-1:1]};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mc     <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if (start) begin
            mc     <= a;
            acc_hi <= '0;
            acc_lo <= b;
        end else if (step) begin
            {acc_hi, acc_lo} <= {hi, lo};
        end
    end
endmodule

// File: rtl/tt_um_sunaofurukawa_cpu_regs.sv
// tt_um_sunaofurukawa_cpu_regs: register-file CPU tile with immediate bus, flags and sequential MUL
module tt_um_sunaofurukawa_cpu_regs
    import cpu_regs_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NREGS  = 4,
    parameter int MUL_EN = 1
) (
    input logic clk,
    input logic rst_n,
    tt_um_sunaofurukawa_cpu_regs_if.slave io
);
    localparam int IW = (NREGS > 2) ? 2 : 1;
    localparam int CW = $clog2(WIDTH + 1);
    logic             ir_valid;
    logic [3:0]       ir_op;
    logic [1:0]       ir_rd, ir_rs;
    logic [WIDTH-1:0] ir_imm;
    logic [WIDTH-1:0] regs [NREGS];
    logic [2:0]       flags;
    logic [WIDTH-1:0] disp;
    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] a, b, res, show_val, mul_lo, mul_hi;
    logic             cy, wr, clr, show, mul_start, mul_step, busy;
    assign a = regs[ir_rd[IW-1:0]];
    assign b = regs[ir_rs[IW-1:0]];
    // the final MUL step writes back on the same edge the next instruction is captured
    assign busy = (state == S_MUL && cnt != CW'(1)) || (ir_valid && ir_op == OP_MUL && MUL_EN != 0);
    assign io.uo_out  = 8'(disp);
    assign io.uio_out = '0;
    assign io.uio_oe  = '0;
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        res       = '0;
        cy        = 1'b0;
        wr        = 1'b0;
        clr       = 1'b0;
        show      = 1'b0;
        show_val  = '0;
        if (state == S_MUL) begin
            mul_step = 1'b1;
            cnt_n    = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state_n = S_IDLE;
                wr      = 1'b1;
                res     = mul_lo;
                cy      = |mul_hi;
            end
        end else if (ir_valid) begin
            case (ir_op)
                OP_ADD:   begin {cy, res} = {1'b0, a} + {1'b0, b}; wr = 1'b1; end
                OP_SUB:   begin {cy, res} = {1'b0, a} - {1'b0, b}; wr = 1'b1; end
                OP_AND:   begin res = a & b; wr = 1'b1; end
                OP_OR:    begin res = a | b; wr = 1'b1; end
                OP_NOT:   begin res = ~a; wr = 1'b1; end
                OP_XOR:   begin res = a ^ b; wr = 1'b1; end
                OP_LDI:   begin res = ir_imm; wr = 1'b1; end
                OP_ADDI:  begin {cy, res} = {1'b0, a} + {1'b0, ir_imm}; wr = 1'b1; end
                OP_SHL:   begin {cy, res} = {a, 1'b0}; wr = 1'b1; end
                OP_SHR:   begin {res, cy} = {1'b0, a}; wr = 1'b1; end
                OP_MOV:   begin res = b; wr = 1'b1; end
                OP_MUL:   if (MUL_EN != 0) begin state_n = S_MUL; cnt_n = CW'(WIDTH); mul_start = 1'b1; end
                OP_SHOW:  begin show = 1'b1; show_val = a; end
                OP_FLAGS: begin show = 1'b1; show_val = WIDTH'(flags); end
                OP_CLR:   clr = 1'b1;
                default:  ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_valid <= 1'b0;
            ir_op    <= '0;
            ir_rd    <= '0;
            ir_rs    <= '0;
            ir_imm   <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            flags    <= '0;
            disp     <= '0;
            state    <= S_IDLE;
            cnt      <= '0;
        end else if (io.ena) begin
            ir_valid <= !busy;
            if (!busy) begin
                ir_op  <= io.ui_in[3:0];
                ir_rd  <= io.ui_in[5:4];
                ir_rs  <= io.ui_in[7:6];
                ir_imm <= io.uio_in[WIDTH-1:0];
            end
            state <= state_n;
            cnt   <= cnt_n;
            if (clr) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            if (wr) begin
                regs[ir_rd[IW-1:0]] <= res;
                disp                <= res;
                flags[F_Z]          <= ~|res;
                flags[F_C]          <= cy;
                flags[F_N]          <= res[WIDTH-1];
            end
            if (show) disp <= show_val;
        end
    end
    if (MUL_EN != 0) begin : g_mul
        cpu_mul_seq #(.WIDTH(WIDTH)) u_mul (
            .clk  (clk),
            .rst_n(rst_n),
            .start(io.ena && mul_start),
            .step (io.ena && mul_step),
            .a    (a),
            .b    (b),
            .lo   (mul_lo),
            .hi   (mul_hi)
        );
    end else begin : g_nomul
        assign mul_lo = '0;
        assign mul_hi = '0;
    end
endmodule

// File: tb/tb_tt_um_sunaofurukawa_cpu_regs.sv
// tb_tt_um_sunaofurukawa_cpu_regs: instruction-level model of the CPU tile checked every cycle, plus literal pins
module tb_tt_um_sunaofurukawa_cpu_regs;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    tt_um_sunaofurukawa_cpu_regs_if io();
    tt_um_sunaofurukawa_cpu_regs #(.WIDTH(W), .NREGS(4), .MUL_EN(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io)
    );
    always #5 clk = ~clk;
    int n_tests = 0;
    int n_fail = 0;
    int m_regs [4];
    int m_disp = 0;
    bit mz, mc, mn;
    bit pend_v;
    logic [7:0] pend_ui, pend_imm;
    int pend_left = 0;
    int drop = 0;
    logic [15:0] tv [12] = '{16'h075A, 16'h173C, 16'h27F0, 16'h370F, 16'h4300, 16'hE400,
                             16'h1600, 16'h3B00, 16'hE100, 16'hB200, 16'h1880, 16'h2D00};
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic apply(input logic [7:0] ui, input logic [7:0] imm);
        int op, rd, rs, va, vb, r, c;
        bit wr;
        op = int'(ui[3:0]);
        rd = int'(ui[5:4]);
        rs = int'(ui[7:6]);
        va = m_regs[rd];
        vb = m_regs[rs];
        r = 0;
        c = 0;
        wr = 1'b1;
        case (op)
            1: begin r = va + vb; c = (r > 255) ? 1 : 0; end
            2: begin r = va - vb; c = (va < vb) ? 1 : 0; end
            3: r = va & vb;
            4: r = va | vb;
            5: r = ~va;
            6: r = va ^ vb;
            7: r = int'(imm);
            8: begin r = va + int'(imm); c = (r > 255) ? 1 : 0; end
            9: begin r = va * 2; c = va / 128; end
            10: begin r = va / 2; c = va % 2; end
            11: r = vb;
            12: begin r = va * vb; c = (r > 255) ? 1 : 0; end
            13: begin m_disp = va; wr = 1'b0; end
            14: begin m_disp = (mn ? 4 : 0) + (mc ? 2 : 0) + (mz ? 1 : 0); wr = 1'b0; end
            15: begin for (int i = 0; i < 4; i++) m_regs[i] = 0; wr = 1'b0; end
            default: wr = 1'b0;
        endcase
        if (wr) begin
            r = r & 255;
            m_regs[rd] = r;
            m_disp = r;
            mz = (r == 0);
            mn = (r >= 128);
            mc = (c != 0);
        end
    endtask
    // an accepted MUL completes WIDTH+1 enabled edges later and blanks the pins for WIDTH edges
    task automatic model_edge(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] imm);
        if (!r) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 0;
            m_disp = 0;
            mz = 0;
            mc = 0;
            mn = 0;
            pend_v = 0;
            drop = 0;
        end else if (e) begin
            if (pend_v) begin
                pend_left--;
                if (pend_left == 0) begin
                    apply(pend_ui, pend_imm);
                    pend_v = 0;
                end
            end
            if (drop > 0) drop--;
            else begin
                pend_v = 1;
                pend_ui = ui;
                pend_imm = imm;
                pend_left = (ui[3:0] == 4'hC) ? W + 1 : 1;
                drop = (ui[3:0] == 4'hC) ? W : 0;
            end
        end
    endtask
    task automatic cyc(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] imm);
        rst_n = r;
        io.ena = e;
        io.ui_in = ui;
        io.uio_in = imm;
        @(posedge clk);
        #1;
        model_edge(r, e, ui, imm);
        @(negedge clk);
        check("model uo_out", int'(io.uo_out), m_disp);
        check("uio_out", int'(io.uio_out), 0);
        check("uio_oe", int'(io.uio_oe), 0);
    endtask
    task automatic run(input logic [7:0] ui, input logic [7:0] imm);
        cyc(1'b1, 1'b1, ui, imm);
    endtask
    task automatic lit(input string name, input int exp);
        check(name, int'(io.uo_out), exp);
        check({name, " model"}, m_disp, exp);
    endtask
    initial begin
        cyc(1'b0, 1'b1, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 8'h00, 8'h00);
        lit("reset", 8'h00);
        run(8'h07, 8'h05);
        lit("ldi pending", 8'h00);
        run(8'h00, 8'h00);
        lit("ldi r0", 8'h05);
        run(8'h17, 8'hFF);
        run(8'h07, 8'h01);
        run(8'h41, 8'h00);
        run(8'h0E, 8'h00);
        lit("add wrap", 8'h00);
        run(8'h00, 8'h00);
        lit("add flags", 8'h03);
        run(8'h07, 8'h03);
        run(8'h17, 8'h05);
        run(8'h42, 8'h00);
        run(8'h0E, 8'h00);
        lit("sub borrow", 8'hFE);
        run(8'h00, 8'h00);
        lit("sub flags", 8'h06);
        run(8'h27, 8'h81);
        run(8'h29, 8'h00);
        run(8'h0E, 8'h00);
        lit("shl", 8'h02);
        run(8'h2A, 8'h00);
        lit("shl flags", 8'h02);
        run(8'h25, 8'h00);
        lit("shr", 8'h01);
        run(8'h28, 8'h03);
        lit("not", 8'hFE);
        run(8'h0E, 8'h00);
        lit("addi wrap", 8'h01);
        run(8'h0F, 8'h00);
        lit("addi flags", 8'h02);
        run(8'h2D, 8'h00);
        lit("clr keeps display", 8'h02);
        run(8'h00, 8'h00);
        lit("clr r2", 8'h00);
        for (int i = 0; i < 12; i++) run(tv[i][15:8], tv[i][7:0]);
        run(8'h00, 8'h00);
        lit("table r2", 8'h17);
        run(8'h07, 8'h0C);
        run(8'h17, 8'h0B);
        run(8'h4C, 8'h00);
        for (int i = 0; i < 8; i++) run(8'h07, 8'hAA);
        lit("mul pending", 8'h0B);
        run(8'h0D, 8'h00);
        lit("mul result", 8'h84);
        run(8'h0E, 8'h00);
        lit("show r0", 8'h84);
        run(8'h00, 8'h00);
        lit("mul flags", 8'h04);
        run(8'h07, 8'h10);
        run(8'h17, 8'h10);
        run(8'h4C, 8'h00);
        for (int i = 0; i < 8; i++) run(8'h00, 8'h00);
        run(8'h0E, 8'h00);
        lit("mul overflow", 8'h00);
        run(8'h00, 8'h00);
        lit("mul overflow flags", 8'h03);
        run(8'h07, 8'h0C);
        run(8'h17, 8'h0B);
        run(8'h4C, 8'h00);
        for (int i = 0; i < 3; i++) run(8'h07, 8'hAA);
        cyc(1'b0, 1'b1, 8'h07, 8'hAA);
        lit("reset mid mul", 8'h00);
        run(8'h07, 8'h33);
        run(8'h1D, 8'h00);
        lit("ldi after reset", 8'h33);
        run(8'h00, 8'h00);
        lit("show r1 after reset", 8'h00);
        run(8'h07, 8'h0C);
        run(8'h17, 8'h0B);
        run(8'h4C, 8'h00);
        run(8'h07, 8'hAA);
        run(8'h07, 8'hAA);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h07, 8'hAA);
        lit("ena low mid mul", 8'h0B);
        for (int i = 0; i < 6; i++) run(8'h07, 8'hAA);
        lit("stalled mul pending", 8'h0B);
        run(8'h00, 8'h00);
        lit("stalled mul result", 8'h84);
        cyc(1'b1, 1'b0, 8'h07, 8'h55);
        cyc(1'b1, 1'b0, 8'h07, 8'h55);
        lit("ena low ldi", 8'h84);
        run(8'h1D, 8'h00);
        run(8'h0D, 8'h00);
        lit("show r1", 8'h0B);
        run(8'h00, 8'h00);
        lit("r0 kept", 8'h84);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
